sub32_serial: RTL and testbench

SUB32_SERIAL -- requirements
Module: sub32_serial

---
 rtl/sub32_serial.sv | 121 ++++++++++++
 tb/tb_sub32_serial.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sub32_serial.sv
// Bit-serial sign-magnitude subtractor: diff = num1 - num2.
// One magnitude bit per clock, LSB first, then a fix-up cycle for sign/borrow.
module sub32_serial #(
    parameter int BIT_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 start,
    input  logic [BIT_DEPTH-1:0] num1,
    input  logic [BIT_DEPTH-1:0] num2,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_DEPTH-1:0] diff,
    output logic                 overflow
);

    localparam int M  = BIT_DEPTH - 1;
    localparam int CW = $clog2(BIT_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0] cnt;
    logic [M-1:0]  a, b, r;
    logic          c;
    logic          op_sub;
    logic          sgn1;

    logic          s1n, s2n;
    logic          ai, bi, sum, cout, last;
    logic [M-1:0]  mag;
    logic          rsgn, rovf;

    // -0 operands are folded to +0 before the operation is chosen
    always_comb begin
        s1n  = num1[M] & (|num1[M-1:0]);
        s2n  = num2[M] & (|num2[M-1:0]);
        ai   = a[0];
        bi   = b[0];
        sum  = ai ^ bi ^ c;
        cout = op_sub ? ((~ai & bi) | (~ai & c) | (bi & c))
                      : ((ai & bi) | (ai & c) | (bi & c));
        last = (cnt == CW'(M - 1));
    end

    // a final borrow means |num2| > |num1|: negate and flip sign
    always_comb begin
        mag  = (op_sub && c) ? (-r) : r;
        rovf = ~op_sub & c;
        rsgn = op_sub ? (sgn1 ^ c) : sgn1;
        if (mag == '0 && !rovf) rsgn = 1'b0;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CALC;
            CALC:    if (last)  state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt      <= '0;
            a        <= '0;
            b        <= '0;
            r        <= '0;
            c        <= 1'b0;
            op_sub   <= 1'b0;
            sgn1     <= 1'b0;
            diff     <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        a      <= num1[M-1:0];
                        b      <= num2[M-1:0];
                        r      <= '0;
                        cnt    <= '0;
                        c      <= 1'b0;
                        sgn1   <= s1n;
                        op_sub <= (s1n == s2n);
                    end
                end
                CALC: begin
                    a   <= a >> 1;
                    b   <= b >> 1;
                    r   <= {sum, r[M-1:1]};
                    c   <= cout;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    diff     <= {rsgn, mag};
                    overflow <= rovf;
                    done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub32_serial.sv
// Self-checking bench for sub32_serial: integer reference model,
// per-cycle comparison, directed corner cases and random traffic.
module tb_sub32_serial;

    logic        clk;
    logic        nrst;
    logic        start;
    logic [31:0] num1, num2;
    logic        ready, busy, done, overflow;
    logic [31:0] diff;

    int checks = 0;
    int errors = 0;

    sub32_serial #(.BIT_DEPTH(32)) dut (
        .clk(clk), .nrst(nrst), .start(start),
        .num1(num1), .num2(num2),
        .ready(ready), .busy(busy), .done(done),
        .diff(diff), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Returns {overflow, diff} using plain signed integer arithmetic
    function automatic logic [32:0] ref_sub(input logic [31:0] x,
                                            input logic [31:0] y);
        longint va, vb, v, m;
        logic [63:0] mb;
        va = longint'(x[30:0]);
        vb = longint'(y[30:0]);
        if (x[31]) va = -va;
        if (y[31]) vb = -vb;
        v  = va - vb;
        m  = (v < 0) ? -v : v;
        mb = 64'(m);
        return {m > 64'sh7FFFFFFF, v < 0, mb[30:0]};
    endfunction

    // Transaction-level model: idle flag, cycle count, held results
    logic        m_idle = 1'b1;
    int          m_cnt  = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_diff = '0;
    logic        m_ovf  = 1'b0;
    logic [32:0] m_pend = '0;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_idle = 1'b1;
            m_cnt  = 0;
            m_done = 1'b0;
            m_diff = '0;
            m_ovf  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_idle) begin
                if (start) begin
                    m_pend = ref_sub(num1, num2);
                    m_idle = 1'b0;
                    m_cnt  = 0;
                end
            end else begin
                m_cnt++;
                if (m_cnt == 32) begin
                    m_idle = 1'b1;
                    m_done = 1'b1;
                    m_diff = m_pend[31:0];
                    m_ovf  = m_pend[32];
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_ready", 64'(ready), 64'(m_idle));
        chk("cyc_busy", 64'(busy), 64'(!m_idle));
        chk("cyc_done", 64'(done), 64'(m_done));
        chk("cyc_diff", 64'(diff), 64'(m_diff));
        chk("cyc_ovf", 64'(overflow), 64'(m_ovf));
    end

    task automatic run_op(input string name, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ed,
                          input logic eo, input int intr);
        int n;
        int extra;
        logic got;
        @(posedge clk);
        #2;
        chk({name, "_ready"}, 64'(ready), 64'd1);
        num1  = x;
        num2  = y;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        n     = 0;
        got   = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            n++;
            #1;
            if (done) got = 1'b1;
            if (intr > 0 && n == intr) begin
                num1  = ~x;
                num2  = y ^ 32'h0000_1234;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk({name, "_seen"}, 64'(got), 64'd1);
        chk({name, "_lat"}, 64'(n), 64'd32);
        chk({name, "_diff"}, 64'(diff), 64'(ed));
        chk({name, "_ovf"}, 64'(overflow), 64'(eo));
        if (intr > 0) begin
            extra = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (done) extra++;
            end
            chk({name, "_onedone"}, 64'(extra), 64'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        unique case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'hFFFF_FFFF;
            4:       return {$urandom_range(0, 1) == 1, 31'($urandom_range(0, 15))};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        int dn;
        nrst  = 1'b0;
        start = 1'b0;
        num1  = '0;
        num2  = '0;

        chk("model_5m3", 64'(ref_sub(32'h5, 32'h3)), 64'h0_0000_0002);
        chk("model_3m5", 64'(ref_sub(32'h3, 32'h5)), 64'h0_8000_0002);
        chk("model_ovfp", 64'(ref_sub(32'h7FFF_FFFF, 32'h8000_0001)),
            64'h1_0000_0000);
        chk("model_ovfn", 64'(ref_sub(32'hFFFF_FFFF, 32'h0000_0001)),
            64'h1_8000_0000);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        #1;
        nrst = 1'b1;

        run_op("d5m3", 32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 0);
        run_op("d3m5", 32'h0000_0003, 32'h0000_0005, 32'h8000_0002, 1'b0, 0);
        run_op("dneq", 32'h8000_0004, 32'h8000_0004, 32'h0000_0000, 1'b0, 0);
        run_op("dovp", 32'h7FFF_FFFF, 32'h8000_0001, 32'h0000_0000, 1'b1, 0);
        run_op("dovn", 32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 0);
        run_op("dnz", 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 0);
        run_op("dign", 32'h0000_0064, 32'h0000_0014, 32'h0000_0050, 1'b0, 5);

        // abort mid-operation with reset
        @(posedge clk);
        #2;
        num1  = 32'h0000_0100;
        num2  = 32'h0000_0001;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_diff", 64'(diff), 64'd0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        @(posedge clk);
        #2;
        nrst = 1'b1;
        dn = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        chk("abort_nodone", 64'(dn), 64'd0);
        run_op("d9m2", 32'h0000_0009, 32'h0000_0002, 32'h0000_0007, 1'b0, 0);

        // random traffic; start often held through done for back-to-back
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            start = ($urandom_range(0, 3) != 0);
            num1  = pick();
            num2  = pick();
        end
        @(posedge clk);
        #2;
        start = 1'b0;
        n = 0;
        while (n < 40 && !ready) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("final_idle", 64'(ready), 64'd1);
        @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
